// File: rtl/booth_seq_mult_if.sv
// Handshake and operand/result bundle between the execute stage and the
// sequential Booth multiplier.
interface booth_seq_mult_if #(
  parameter int unsigned WWidth = 32
);
  localparam int unsigned IterW = $clog2(WWidth) + 1;

  logic                  start;
  logic                  flush;
  logic [WWidth-1:0]     m;
  logic [WWidth-1:0]     r;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [2*WWidth-1:0]   product;
  logic [WWidth-1:0]     ans;
  logic                  overflow;
  logic [IterW-1:0]      iter;

  modport master (
    output start, flush, m, r,
    input  ready, busy, done, product, ans, overflow, iter
  );

  modport slave (
    input  start, flush, m, r,
    output ready, busy, done, product, ans, overflow, iter
  );
endinterface

// File: rtl/booth_seq_mult.sv
// Radix-2 Booth multiplier: one shared (W+1)-bit add/sub per cycle over W cycles,
// with a start/ready/done handshake and results held until the next DONE.
module booth_seq_mult #(
  parameter int unsigned WWidth = 32
) (
  input logic             clk,
  input logic             reset,
  booth_seq_mult_if.slave bus
);
  localparam int unsigned PW    = 2 * WWidth + 2;
  localparam int unsigned IterW = $clog2(WWidth) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q;
  logic [PW-1:0]       p_q;
  logic [WWidth:0]     m_q;
  logic [IterW-1:0]    iter_q;
  logic                ready_q, busy_q, done_q, overflow_q;
  logic [2*WWidth-1:0] product_q;
  logic [WWidth-1:0]   ans_q;

  logic [WWidth:0]     acc, acc_sum;
  logic [PW-1:0]       p_add, p_next;
  logic [IterW-1:0]    iter_next;
  logic                last_step, ovf_next;

  always_comb begin
    acc = p_q[PW-1:WWidth+1];
    unique case (p_q[1:0])
      2'b01:   acc_sum = acc + m_q;
      2'b10:   acc_sum = acc - m_q;
      default: acc_sum = acc;
    endcase
    p_add     = {acc_sum, p_q[WWidth:0]};
    p_next    = {p_add[PW-1], p_add[PW-1:1]};
    iter_next = iter_q + 1'b1;
    last_step = (iter_next == IterW'(WWidth));
    // Fits in W signed bits only if the upper word plus ans sign are all equal.
    ovf_next  = !((&p_next[2*WWidth:WWidth]) || !(|p_next[2*WWidth:WWidth]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      p_q        <= '0;
      m_q        <= '0;
      iter_q     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      product_q  <= '0;
      ans_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (!bus.flush && bus.start) begin
            m_q     <= {bus.m[WWidth-1], bus.m};
            p_q     <= {{(WWidth+1){1'b0}}, bus.r, 1'b0};
            iter_q  <= '0;
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          if (bus.flush) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            p_q    <= p_next;
            iter_q <= iter_next;
            if (last_step) begin
              state_q    <= StDone;
              ready_q    <= 1'b1;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              product_q  <= p_next[2*WWidth:1];
              ans_q      <= p_next[WWidth:1];
              overflow_q <= ovf_next;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.product  = product_q;
  assign bus.ans      = ans_q;
  assign bus.overflow = overflow_q;
  assign bus.iter     = iter_q;
endmodule
